sys_array_tile_sequencer: RTL and testbench

Downstream companion of `sys_array_split`. Once a matrix-multiply split is ready, this block walks the output matrix in systolic-array-sized tiles and issues one tile job per (row block, column block, K block) to the array loader over a valid/ready handshake. Each job carries its offsets, its clipped sizes and an accumulate flag, so the loader can stream operand slices and the array can sum partial products across K.

---
 rtl/sys_array_tile_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_sys_array_tile_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_array_tile_sequencer.sv
// Tile job sequencer: walks an MxN output in array-sized tiles (K innermost) and issues one job per handshake.
// Optional feature: define TILE_SEQ_JOB_COUNT_EN to add the job_index / job_total outputs.
module sys_array_tile_sequencer #(
    parameter int ARRAY_W       = 4,
    parameter int ARRAY_L       = 4,
    parameter int ARRAY_MAX_A_W = 4,
    parameter int DIM_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DIM_WIDTH-1:0]   ARRAY_A_W,
    input  logic [DIM_WIDTH-1:0]   ARRAY_A_L,
    input  logic [DIM_WIDTH-1:0]   ARRAY_W_L,
    output logic                   job_valid,
    input  logic                   job_ready,
    output logic [DIM_WIDTH-1:0]   job_row_off,
    output logic [DIM_WIDTH-1:0]   job_col_off,
    output logic [DIM_WIDTH-1:0]   job_k_off,
    output logic [DIM_WIDTH-1:0]   job_rows,
    output logic [DIM_WIDTH-1:0]   job_cols,
    output logic [DIM_WIDTH-1:0]   job_k,
    output logic                   job_acc,
    output logic                   job_last,
    output logic                   busy,
    output logic                   ready,
`ifdef TILE_SEQ_JOB_COUNT_EN
    output logic [DIM_WIDTH-1:0]   job_index,
    output logic [2*DIM_WIDTH-1:0] job_total,
`endif
    output logic                   error
);

    localparam int XW = DIM_WIDTH + 1;
    localparam logic [XW-1:0] ROW_STEP = XW'(ARRAY_W);
    localparam logic [XW-1:0] COL_STEP = XW'(ARRAY_L);
    localparam logic [XW-1:0] K_STEP   = XW'(ARRAY_MAX_A_W);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t               state_q, state_d;
    logic [DIM_WIDTH-1:0] mDim_q, mDim_d;
    logic [DIM_WIDTH-1:0] kDim_q, kDim_d;
    logic [DIM_WIDTH-1:0] nDim_q, nDim_d;
    logic [DIM_WIDTH-1:0] rowOff_q, rowOff_d;
    logic [DIM_WIDTH-1:0] colOff_q, colOff_d;
    logic [DIM_WIDTH-1:0] kOff_q, kOff_d;
    logic                 error_q, error_d;

    logic [XW-1:0] rowRem, colRem, kRem;
    logic [XW-1:0] rowSize, colSize, kSize;
    logic [XW-1:0] rowNext, colNext, kNext;
    logic          rowEnd, colEnd, kEnd, allLast;
    logic          issuing, handshake, dimsOk;

    function automatic logic [XW-1:0] clipTo(input logic [XW-1:0] rem, input logic [XW-1:0] step);
        return (rem < step) ? rem : step;
    endfunction

    // Remaining extents and next offsets use one extra bit so neither can wrap near the top of the range.
    always_comb begin
        rowRem    = {1'b0, mDim_q} - {1'b0, rowOff_q};
        colRem    = {1'b0, nDim_q} - {1'b0, colOff_q};
        kRem      = {1'b0, kDim_q} - {1'b0, kOff_q};
        rowSize   = clipTo(rowRem, ROW_STEP);
        colSize   = clipTo(colRem, COL_STEP);
        kSize     = clipTo(kRem, K_STEP);
        rowNext   = {1'b0, rowOff_q} + ROW_STEP;
        colNext   = {1'b0, colOff_q} + COL_STEP;
        kNext     = {1'b0, kOff_q} + K_STEP;
        rowEnd    = rowNext >= {1'b0, mDim_q};
        colEnd    = colNext >= {1'b0, nDim_q};
        kEnd      = kNext >= {1'b0, kDim_q};
        allLast   = rowEnd && colEnd && kEnd;
        issuing   = (state_q == ISSUE);
        handshake = issuing && job_ready;
        dimsOk    = (ARRAY_A_W != '0) && (ARRAY_A_L != '0) && (ARRAY_W_L != '0);
    end

    always_comb begin
        state_d  = state_q;
        mDim_d   = mDim_q;
        kDim_d   = kDim_q;
        nDim_d   = nDim_q;
        rowOff_d = rowOff_q;
        colOff_d = colOff_q;
        kOff_d   = kOff_q;
        error_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (dimsOk) begin
                        mDim_d   = ARRAY_A_W;
                        kDim_d   = ARRAY_A_L;
                        nDim_d   = ARRAY_W_L;
                        rowOff_d = '0;
                        colOff_d = '0;
                        kOff_d   = '0;
                        state_d  = ISSUE;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (job_ready) begin
                    // Odometer order: K wraps into column, column wraps into row.
                    if (allLast) begin
                        rowOff_d = '0;
                        colOff_d = '0;
                        kOff_d   = '0;
                        state_d  = IDLE;
                    end else if (!kEnd) begin
                        kOff_d = DIM_WIDTH'(kNext);
                    end else if (!colEnd) begin
                        kOff_d   = '0;
                        colOff_d = DIM_WIDTH'(colNext);
                    end else begin
                        kOff_d   = '0;
                        colOff_d = '0;
                        rowOff_d = DIM_WIDTH'(rowNext);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mDim_q   <= '0;
            kDim_q   <= '0;
            nDim_q   <= '0;
            rowOff_q <= '0;
            colOff_q <= '0;
            kOff_q   <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mDim_q   <= mDim_d;
            kDim_q   <= kDim_d;
            nDim_q   <= nDim_d;
            rowOff_q <= rowOff_d;
            colOff_q <= colOff_d;
            kOff_q   <= kOff_d;
            error_q  <= error_d;
        end
    end

    // Offsets are already zero outside ISSUE; sizes and flags are forced to zero there.
    assign job_valid   = issuing;
    assign job_row_off = rowOff_q;
    assign job_col_off = colOff_q;
    assign job_k_off   = kOff_q;
    assign job_rows    = issuing ? DIM_WIDTH'(rowSize) : '0;
    assign job_cols    = issuing ? DIM_WIDTH'(colSize) : '0;
    assign job_k       = issuing ? DIM_WIDTH'(kSize) : '0;
    assign job_acc     = issuing && (kOff_q != '0);
    assign job_last    = issuing && allLast;
    assign busy        = issuing;
    assign ready       = !issuing;
    assign error       = error_q;

`ifdef TILE_SEQ_JOB_COUNT_EN
    logic [DIM_WIDTH-1:0]   jobIndex_q, jobIndex_d;
    logic [2*DIM_WIDTH-1:0] jobTotal_q, jobTotal_d;
    logic [XW-1:0]          rowBlocks, colBlocks, kBlocks;

    // The total is taken straight from the start-cycle dimensions so it is valid alongside the first job.
    always_comb begin
        rowBlocks  = ({1'b0, ARRAY_A_W} + XW'(ARRAY_W - 1)) / ROW_STEP;
        colBlocks  = ({1'b0, ARRAY_W_L} + XW'(ARRAY_L - 1)) / COL_STEP;
        kBlocks    = ({1'b0, ARRAY_A_L} + XW'(ARRAY_MAX_A_W - 1)) / K_STEP;
        jobTotal_d = jobTotal_q;
        jobIndex_d = jobIndex_q;
        if (!issuing) begin
            jobIndex_d = '0;
            if (start && dimsOk) begin
                jobTotal_d = (2*DIM_WIDTH)'(rowBlocks) * (2*DIM_WIDTH)'(colBlocks)
                           * (2*DIM_WIDTH)'(kBlocks);
            end
        end else if (handshake) begin
            jobIndex_d = allLast ? '0 : jobIndex_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            jobIndex_q <= '0;
            jobTotal_q <= '0;
        end else begin
            jobIndex_q <= jobIndex_d;
            jobTotal_q <= jobTotal_d;
        end
    end

    assign job_index = jobIndex_q;
    assign job_total = jobTotal_q;
`endif

endmodule

// File: tb/tb_sys_array_tile_sequencer.sv
// Randomized self-checking bench for sys_array_tile_sequencer against a job-list reference model.
// Build with TILE_SEQ_JOB_COUNT_EN defined to also check job_index / job_total.
module tb_sys_array_tile_sequencer;

    localparam int DW = 16;
    localparam int TW = 4;
    localparam int TL = 4;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] ARRAY_A_W, ARRAY_A_L, ARRAY_W_L;
    logic          job_valid, job_ready;
    logic [DW-1:0] job_row_off, job_col_off, job_k_off, job_rows, job_cols, job_k;
    logic          job_acc, job_last, busy, ready, error;
`ifdef TILE_SEQ_JOB_COUNT_EN
    logic [DW-1:0]   job_index;
    logic [2*DW-1:0] job_total;
`endif

    sys_array_tile_sequencer #(
        .ARRAY_W(TW), .ARRAY_L(TL), .ARRAY_MAX_A_W(TD), .DIM_WIDTH(DW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .ARRAY_A_W(ARRAY_A_W), .ARRAY_A_L(ARRAY_A_L), .ARRAY_W_L(ARRAY_W_L),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_row_off(job_row_off), .job_col_off(job_col_off), .job_k_off(job_k_off),
        .job_rows(job_rows), .job_cols(job_cols), .job_k(job_k),
        .job_acc(job_acc), .job_last(job_last), .busy(busy), .ready(ready),
`ifdef TILE_SEQ_JOB_COUNT_EN
        .job_index(job_index), .job_total(job_total),
`endif
        .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ro, co, ko, r, c, k;
        bit acc, last;
    } job_t;

    job_t   expQ[$];
    bit     expError = 1'b0;
    int     expIdx = 0;
    longint expTotal = 0;
    int     total = 0;
    int     bad = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the full list of jobs for one run, straight from the tiling rules.
    function automatic void buildRun(input int m, input int kd, input int n);
        for (int r = 0; r < m; r += TW)
            for (int c = 0; c < n; c += TL)
                for (int k = 0; k < kd; k += TD) begin
                    job_t j;
                    j.ro   = r;
                    j.co   = c;
                    j.ko   = k;
                    j.r    = (m - r < TW) ? m - r : TW;
                    j.c    = (n - c < TL) ? n - c : TL;
                    j.k    = (kd - k < TD) ? kd - k : TD;
                    j.acc  = (k != 0);
                    j.last = (r + TW >= m) && (c + TL >= n) && (k + TD >= kd);
                    expQ.push_back(j);
                end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            expQ.delete();
            expError = 1'b0;
            expIdx   = 0;
            expTotal = 0;
        end else begin
            expError = 1'b0;
            if (expQ.size() == 0) begin
                expIdx = 0;
                if (start) begin
                    if (ARRAY_A_W != 0 && ARRAY_A_L != 0 && ARRAY_W_L != 0) begin
                        buildRun(int'(ARRAY_A_W), int'(ARRAY_A_L), int'(ARRAY_W_L));
                        expTotal = longint'(expQ.size());
                    end else begin
                        expError = 1'b1;
                    end
                end
            end else if (job_ready) begin
                expQ.delete(0);
                expIdx = (expQ.size() == 0) ? 0 : expIdx + 1;
            end
        end
    end

    task automatic compareAll();
        job_t f;
        bit   v;
        v = (expQ.size() != 0);
        f = '{default: 0};
        if (v) f = expQ[0];
        checkOutput("job_valid", 64'(job_valid), 64'(v));
        checkOutput("busy", 64'(busy), 64'(v));
        checkOutput("ready", 64'(ready), 64'(!v));
        checkOutput("error", 64'(error), 64'(expError));
        checkOutput("job_row_off", 64'(job_row_off), 64'(f.ro));
        checkOutput("job_col_off", 64'(job_col_off), 64'(f.co));
        checkOutput("job_k_off", 64'(job_k_off), 64'(f.ko));
        checkOutput("job_rows", 64'(job_rows), 64'(f.r));
        checkOutput("job_cols", 64'(job_cols), 64'(f.c));
        checkOutput("job_k", 64'(job_k), 64'(f.k));
        checkOutput("job_acc", 64'(job_acc), 64'(f.acc));
        checkOutput("job_last", 64'(job_last), 64'(f.last));
`ifdef TILE_SEQ_JOB_COUNT_EN
        checkOutput("job_index", 64'(job_index), 64'(expIdx));
        checkOutput("job_total", 64'(job_total), 64'(expTotal));
`endif
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            compareAll();
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that samples the start.
    task automatic applyStimulus(input int m, input int k, input int n);
        start     = 1'b1;
        ARRAY_A_W = DW'(m);
        ARRAY_A_L = DW'(k);
        ARRAY_W_L = DW'(n);
        @(posedge clk);
        #1;
        start     = 1'b0;
        ARRAY_A_W = DW'($urandom);
        ARRAY_A_L = DW'($urandom);
        ARRAY_W_L = DW'($urandom);
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while ((expQ.size() != 0 || ready !== 1'b1) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("idle_reached", 64'(ready), 64'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        job_ready = 1'b0;
        ARRAY_A_W = '0;
        ARRAY_A_L = '0;
        ARRAY_W_L = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_ready", 64'(ready), 64'(1));
        checkOutput("reset_valid", 64'(job_valid), 64'(0));

        // First run with a 5-cycle stall on the second job.
        job_ready = 1'b1;
        applyStimulus(5, 2, 5);
        checkOutput("model_jobs_5x2x5", 64'(expQ.size()), 64'(4));
        checkOutput("model_job1_col", 64'(expQ[1].co), 64'(4));
        checkOutput("model_job1_cols", 64'(expQ[1].c), 64'(1));
        checkOutput("model_job3_last", 64'(expQ[3].last), 64'(1));
        checkOutput("first_rows", 64'(job_rows), 64'(4));
        checkOutput("first_k", 64'(job_k), 64'(2));
        @(posedge clk);
        #1;
        job_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_col_off", 64'(job_col_off), 64'(4));
            checkOutput("stall_cols", 64'(job_cols), 64'(1));
            @(posedge clk);
            #1;
        end
        job_ready = 1'b1;
        waitIdle(20);
`ifdef TILE_SEQ_JOB_COUNT_EN
        checkOutput("held_total", 64'(job_total), 64'(4));
`endif

        // Deep K with a second start pulse during the run.
        applyStimulus(4, 10, 4);
        checkOutput("model_jobs_4x10x4", 64'(expQ.size()), 64'(3));
        checkOutput("model_k2_off", 64'(expQ[2].ko), 64'(8));
        checkOutput("model_k2_size", 64'(expQ[2].k), 64'(2));
        checkOutput("model_k1_acc", 64'(expQ[1].acc), 64'(1));
        @(posedge clk);
        #1;
        start     = 1'b1;
        ARRAY_A_W = 16'd8;
        ARRAY_A_L = 16'd8;
        ARRAY_W_L = 16'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle(20);

        // Zero dimension is rejected.
        applyStimulus(3, 0, 3);
        checkOutput("err_pulse", 64'(error), 64'(1));
        checkOutput("err_no_valid", 64'(job_valid), 64'(0));
        @(posedge clk);
        #1;
        checkOutput("err_cleared", 64'(error), 64'(0));

        // Reset after the first handshake, then restart.
        applyStimulus(5, 2, 5);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("rst_valid", 64'(job_valid), 64'(0));
        checkOutput("rst_ready", 64'(ready), 64'(1));
        applyStimulus(5, 2, 5);
        checkOutput("restart_col_off", 64'(job_col_off), 64'(0));
        checkOutput("restart_valid", 64'(job_valid), 64'(1));
        waitIdle(20);

        // Randomized runs with backpressure, stray starts and occasional reset.
        for (int run = 0; run < 40; run++) begin
            int n;
            job_ready = 1'($urandom_range(0, 1));
            applyStimulus($urandom_range(0, 13), $urandom_range(0, 13), $urandom_range(0, 13));
            n = 0;
            while (expQ.size() != 0 && n < 2000) begin
                job_ready = ($urandom_range(0, 9) < 7);
                start     = ($urandom_range(0, 19) == 0);
                reset     = ($urandom_range(0, 149) == 0);
                ARRAY_A_W = DW'($urandom_range(1, 9));
                ARRAY_A_L = DW'($urandom_range(1, 9));
                ARRAY_W_L = DW'($urandom_range(1, 9));
                @(posedge clk);
                #1;
                n++;
            end
            start     = 1'b0;
            reset     = 1'b0;
            job_ready = 1'b1;
            waitIdle(50);
        end

        // Top-of-range K: last offset 65532 must not wrap.
        job_ready = 1'b1;
        applyStimulus(1, 65535, 1);
        checkOutput("model_big_jobs", 64'(expQ.size()), 64'(16384));
        checkOutput("model_big_last_k", 64'(expQ[16383].k), 64'(3));
        waitIdle(17000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
